// File: rtl/prf_free_list_if.sv
// -----------------------------------------------------------------------------
// prf_free_list_if
//
// Groups the rename/commit side of the integer physical-register free list.
// The rename/commit pipeline uses the master modport. The free list uses the
// slave modport.
//
//   alloc_req     [WAYS]         per-way request for a new destination PRF
//   alloc_prf     [WAYS][IDX]    PRF granted to each requesting way
//   allocatable                  any alloc_req pattern can be served this cycle
//   release_valid [WAYS]         per-way commit release strobe
//   release_prf   [WAYS][IDX]    stale PRF returned by commit
//   check / check_index          snapshot the allocation pointer into a slot
//   recover / recover_index      restore the allocation pointer from a slot
//   free_count    [IDX+1]        number of free PRFs
// -----------------------------------------------------------------------------
interface prf_free_list_if #(
    parameter int WAYS     = 4,
    parameter int PRF_SIZE = 64,
    parameter int CP_NUM   = 2
);
    localparam int IDX = $clog2(PRF_SIZE);
    localparam int CPI = (CP_NUM > 1) ? $clog2(CP_NUM) : 1;

    logic [WAYS-1:0]           alloc_req;
    logic [WAYS-1:0][IDX-1:0]  alloc_prf;
    logic                      allocatable;
    logic [WAYS-1:0]           release_valid;
    logic [WAYS-1:0][IDX-1:0]  release_prf;
    logic                      check;
    logic [CPI-1:0]            check_index;
    logic                      recover;
    logic [CPI-1:0]            recover_index;
    logic [IDX:0]              free_count;

    modport master (
        output alloc_req,
        input  alloc_prf,
        input  allocatable,
        output release_valid,
        output release_prf,
        output check,
        output check_index,
        output recover,
        output recover_index,
        input  free_count
    );

    modport slave (
        input  alloc_req,
        output alloc_prf,
        output allocatable,
        input  release_valid,
        input  release_prf,
        input  check,
        input  check_index,
        input  recover,
        input  recover_index,
        output free_count
    );
endinterface

// File: rtl/prf_free_list.sv
// -----------------------------------------------------------------------------
// prf_free_list
//
// Free list for the integer physical register file. It is a circular FIFO of
// PRF numbers:
//   - rename pops up to WAYS entries per cycle at the head (allocation),
//   - commit pushes up to WAYS stale entries per cycle at the tail (release),
//   - branch checkpoints save the head pointer, and recovery restores it.
//     This works because the entries between a saved head and the current head
//     are not overwritten until the tail passes them.
//
// Both pointers are IDX+1 bits wide and wrap modulo 2*PRF_SIZE. The extra bit
// separates the full state from the empty state through
// free_count = tail - head. Only the low IDX bits address the FIFO.
//
// Ports
//   clock   single clock, all state updates on the rising edge
//   reset   asynchronous, active-low
//   fl      prf_free_list_if.slave (alloc / release / checkpoint / free_count)
// -----------------------------------------------------------------------------
module prf_free_list #(
    parameter int WAYS     = 4,
    parameter int PRF_SIZE = 64,
    parameter int ARF_SIZE = 32,
    parameter int CP_NUM   = 2
) (
    input  logic          clock,
    input  logic          reset,
    prf_free_list_if.slave fl
);
    localparam int IDX       = $clog2(PRF_SIZE);
    localparam int FREE_INIT = PRF_SIZE - ARF_SIZE;

    typedef logic [IDX-1:0] prf_t;
    typedef logic [IDX:0]   ptr_t;

    prf_t fifo    [PRF_SIZE];
    ptr_t head;
    ptr_t tail;
    ptr_t cp_head [CP_NUM];

    ptr_t free_count;
    ptr_t alloc_cnt;
    ptr_t rel_cnt;
    ptr_t head_alloc;
    logic alloc_fire;

    prf_t alloc_addr [WAYS];
    prf_t rel_addr   [WAYS];

    // -------------------------------------------------------------------------
    // Compaction: each active way takes the next FIFO slot after the active
    // ways below it. Idle ways do not consume a slot.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the loop. This keeps
        // always_comb free of inferred latches.
        alloc_cnt = '0;
        rel_cnt   = '0;
        for (int i = 0; i < WAYS; i++) begin
            alloc_addr[i] = prf_t'(head[IDX-1:0] + alloc_cnt[IDX-1:0]);
            rel_addr[i]   = prf_t'(tail[IDX-1:0] + rel_cnt[IDX-1:0]);
            if (fl.alloc_req[i]) begin
                alloc_cnt = alloc_cnt + ptr_t'(1);
            end
            if (fl.release_valid[i]) begin
                rel_cnt = rel_cnt + ptr_t'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status and allocation grant
    // -------------------------------------------------------------------------
    assign free_count = tail - head;

    // allocatable does not depend on alloc_req, so rename can use it to build
    // its requests without a combinational loop.
    assign fl.allocatable = (free_count >= ptr_t'(WAYS)) && !fl.recover;
    assign fl.free_count  = free_count;

    assign alloc_fire = fl.allocatable && (|fl.alloc_req);
    assign head_alloc = alloc_fire ? (head + alloc_cnt) : head;

    // The grant is read from the current head only. A PRF released this cycle
    // is written at the clock edge, so it cannot appear here before the next
    // cycle.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            fl.alloc_prf[i] = fifo[alloc_addr[i]];
        end
    end

    // -------------------------------------------------------------------------
    // State update
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= ptr_t'(FREE_INIT);
            for (int c = 0; c < CP_NUM; c++) begin
                cp_head[c] <= '0;
            end
            // NOTE: this storage is reset on purpose. At reset the FIFO must
            // already hold the initial free PRFs ARF_SIZE..PRF_SIZE-1. Slots
            // at and above FREE_INIT lie beyond the tail and are never read
            // before a release writes them. Their values wrap onto the
            // architectural numbers only to keep the reset loop uniform.
            for (int i = 0; i < PRF_SIZE; i++) begin
                fifo[i] <= prf_t'(ARF_SIZE + i);
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All reads
            // in this block then see the values from before the clock edge.
            tail <= tail + rel_cnt;
            for (int i = 0; i < WAYS; i++) begin
                if (fl.release_valid[i]) begin
                    fifo[rel_addr[i]] <= fl.release_prf[i];
                end
            end

            // Recovery has priority over allocation and over a new snapshot.
            // Releases above are still accepted in the same cycle.
            if (fl.recover) begin
                head <= cp_head[fl.recover_index];
            end else begin
                head <= head_alloc;
                // The snapshot includes this cycle's allocation. Recovery then
                // frees only the PRFs handed out after the checkpointed
                // instruction group.
                if (fl.check) begin
                    cp_head[fl.check_index] <= head_alloc;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // A release must never push the free count above the FIFO capacity.
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    logic [IDX+1:0] free_after_release;
    assign free_after_release = {1'b0, free_count} + {1'b0, rel_cnt};

    a_no_overflow: assert property (
        @(posedge clock) disable iff (!reset)
        free_after_release <= (IDX+2)'(PRF_SIZE)
    );
`endif

endmodule

// File: tb/tb_prf_free_list.sv
// -----------------------------------------------------------------------------
// tb_prf_free_list
//
// Directed bench for prf_free_list at the default parameters.
// The driver applies inputs 1 ns after each rising edge and queues the outputs
// expected in that cycle, tagged with the cycle number. The monitor samples on
// the falling edge and compares every expectation whose cycle has arrived.
// -----------------------------------------------------------------------------
module tb_prf_free_list;
    localparam int WAYS     = 4;
    localparam int PRF_SIZE = 64;
    localparam int ARF_SIZE = 32;
    localparam int CP_NUM   = 2;

    typedef logic [WAYS-1:0][5:0] vec_t;

    typedef struct packed {
        int          cyc;
        logic [6:0]  fc;
        logic        alc;
        logic [3:0]  mask;
        vec_t        prf;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cycle = 0;
    int   total = 0;
    int   bad   = 0;

    exp_t  exp_q  [$];
    string name_q [$];

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    prf_free_list_if #(.WAYS(WAYS), .PRF_SIZE(PRF_SIZE), .CP_NUM(CP_NUM)) fl ();

    prf_free_list #(
        .WAYS     (WAYS),
        .PRF_SIZE (PRF_SIZE),
        .ARF_SIZE (ARF_SIZE),
        .CP_NUM   (CP_NUM)
    ) dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic vec_t p4(input int a0, input int a1, input int a2, input int a3);
        vec_t v;
        v[0] = 6'(a0);
        v[1] = 6'(a1);
        v[2] = 6'(a2);
        v[3] = 6'(a3);
        return v;
    endfunction

    // Value of the n-th PRF in the streaming phase.
    function automatic int r(input int n);
        return (n * 7 + 3) % 64;
    endfunction

    task automatic set_inputs(input logic [3:0] req, input logic [3:0] rv, input vec_t rp,
                              input logic chk, input logic ci, input logic rec, input logic ri);
        fl.alloc_req     = req;
        fl.release_valid = rv;
        fl.release_prf   = rp;
        fl.check         = chk;
        fl.check_index   = ci;
        fl.recover       = rec;
        fl.recover_index = ri;
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] rv, input vec_t rp,
                         input logic chk, input logic ci, input logic rec, input logic ri);
        @(posedge clock);
        #1;
        set_inputs(req, rv, rp, chk, ci, rec, ri);
    endtask

    task automatic idle();
        drive(4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic expect_out(input string name, input int fc, input logic alc,
                              input logic [3:0] mask, input vec_t prf);
        exp_t e;
        e.cyc  = cycle;
        e.fc   = 7'(fc);
        e.alc  = alc;
        e.mask = mask;
        e.prf  = prf;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor / scoreboard
    initial begin
        exp_t  e;
        string n;
        forever begin
            @(negedge clock);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cycle) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, ".free_count"}, 32'(fl.free_count), 32'(e.fc));
                check({n, ".allocatable"}, 32'(fl.allocatable), 32'(e.alc));
                for (int w = 0; w < WAYS; w++) begin
                    if (e.mask[w]) begin
                        check($sformatf("%s.alloc_prf[%0d]", n, w),
                              32'(fl.alloc_prf[w]), 32'(e.prf[w]));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        set_inputs(4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Outputs while reset is held low
        repeat (2) @(posedge clock);
        #1;
        expect_out("in_reset", 32, 1'b1, 4'b0001, p4(32, 0, 0, 0));
        @(posedge clock);
        #1;
        reset = 1'b1;

        // 4-wide allocation with a snapshot into slot 1 (post-update head = 4)
        drive(4'b1111, 4'b0000, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        expect_out("alloc4", 32, 1'b1, 4'b1111, p4(32, 33, 34, 35));
        idle();
        expect_out("after_alloc4", 28, 1'b1, 4'b0001, p4(36, 0, 0, 0));

        // Sparse request: compacted onto consecutive entries
        drive(4'b1010, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("compact", 28, 1'b1, 4'b1010, p4(0, 36, 0, 37));
        drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("alloc4_b", 26, 1'b1, 4'b1111, p4(38, 39, 40, 41));

        // Release two PRFs. They must not show in free_count this cycle.
        drive(4'b0000, 4'b0011, p4(1, 2, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("release2", 22, 1'b1, 4'b0001, p4(42, 0, 0, 0));

        // Recover slot 1 together with alloc, check slot 0 and one release
        drive(4'b1111, 4'b0001, p4(3, 0, 0, 0), 1'b1, 1'b0, 1'b1, 1'b1);
        expect_out("recover_cycle", 24, 1'b0, 4'b0000, '0);
        idle();
        expect_out("recovered1", 31, 1'b1, 4'b0001, p4(36, 0, 0, 0));

        // Slot 0 must still hold 0 (the check above was ignored)
        drive(4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_out("recover0_cycle", 31, 1'b0, 4'b0000, '0);
        idle();
        expect_out("cp0_kept", 35, 1'b1, 4'b0001, p4(32, 0, 0, 0));

        // Reset asserted in the middle of a busy cycle
        drive(4'b1111, 4'b1111, p4(7, 8, 9, 10), 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        expect_out("reset_mid", 32, 1'b1, 4'b0001, p4(32, 0, 0, 0));
        @(posedge clock);
        #1;
        set_inputs(4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Checkpoint slot 1 was cleared by reset: recovering it returns to head 0
        drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("post_reset_alloc", 32, 1'b1, 4'b1111, p4(32, 33, 34, 35));
        drive(4'b0000, 4'b0000, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        expect_out("recover_reset_cp", 28, 1'b0, 4'b0000, '0);
        idle();
        expect_out("cp_reset_zero", 32, 1'b1, 4'b0001, p4(32, 0, 0, 0));

        // Drain the list completely
        for (int k = 0; k < 8; k++) begin
            drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            expect_out("drain", 32 - 4 * k, 1'b1, 4'b1111,
                       p4(32 + 4 * k, 33 + 4 * k, 34 + 4 * k, 35 + 4 * k));
        end

        // Empty: requests are ignored and releases refill in order
        drive(4'b1111, 4'b0011, p4(5, 6, 0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("empty", 0, 1'b0, 4'b0000, '0);
        drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("empty_hold", 2, 1'b0, 4'b0001, p4(5, 0, 0, 0));
        drive(4'b0000, 4'b1100, p4(0, 0, 7, 8), 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("release_hi", 2, 1'b0, 4'b0000, '0);
        drive(4'b1111, 4'b0000, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("refill_alloc", 4, 1'b1, 4'b1111, p4(5, 6, 7, 8));

        // Streaming: 4-wide alloc plus 4-wide release, pointers wrap
        drive(4'b0000, 4'b1111, p4(r(0), r(1), r(2), r(3)), 1'b0, 1'b0, 1'b0, 1'b0);
        expect_out("stream_prime", 0, 1'b0, 4'b0000, '0);
        for (int j = 0; j < 40; j++) begin
            drive(4'b1111, 4'b1111,
                  p4(r(4 * j + 4), r(4 * j + 5), r(4 * j + 6), r(4 * j + 7)),
                  1'b0, 1'b0, 1'b0, 1'b0);
            expect_out("stream", 4, 1'b1, 4'b1111,
                       p4(r(4 * j), r(4 * j + 1), r(4 * j + 2), r(4 * j + 3)));
        end
        idle();
        expect_out("stream_end", 4, 1'b1, 4'b0001, p4(r(160), 0, 0, 0));

        // Let the monitor consume everything, with a bounded wait
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
            @(negedge clock);
        end
        #1;
        if (exp_q.size() > 0) begin
            check("queue_drain", 32'(exp_q.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
